cdc_sender: RTL and testbench
=============================

# cdc_sender

Source-domain launcher feeding the team's multi-flop CDC synchronizer across a clock boundary. It accepts words through a valid/ready handshake and registers each one onto a launch register. It holds that register stable for a guaranteed minimum number of source cycles, so the destination's stability filter always captures a settled value. Optionally, it also waits for a toggle acknowledge returned from the destination domain before accepting the next word.

## Interface
- DATA_WIDTH, 8, launched word width
- HOLD_CYCLES, 8, minimum source cycles data_out is held after each launch; legal range ≥1
- SYNC_TIMES, 3, flop stages on the returning ack_toggle; legal range ≥2
- clk  in  1  source-domain clock; the block's only clock
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  word to send
- valid_in  in  1  data_in is valid
- ready_out  out  1  block can accept a word this cycle
- data_out  out  DATA_WIDTH  launch register; drives the destination synchronizer directly, with no logic after the flop
- req_toggle  out  1  flips once per launched word
- ack_toggle  in  1  destination-domain copy of req_toggle; asynchronous to clk
- busy  out  1  high whenever the state is not IDLE

## Operation
- States are IDLE, HOLD and WAIT_ACK.
- Reset values:
  - state = IDLE.
  - data_out = 0.
  - req_toggle = 0.
  - ready_out = 0 (registered); it rises on the first clk edge after reset_n is released.
  - busy = 0.
  - hold counter = 0.
  - ack sync chain = 0.
- IDLE, with ready_out=1:
  - valid_in && ready_out at an edge is an accept.
  - On accept: data_out <= data_in; req_toggle <= ~req_toggle; counter <= HOLD_CYCLES-1; ready_out <= 0; go to HOLD.
  - valid_in with ready_out=0 is ignored. The upstream holds the word until it is accepted.
- HOLD:
  - Counter decrements each edge.
  - At the edge where counter == 0, the state exits HOLD.
  - Without ACK: go to IDLE and set ready_out <= 1.
  - With ACK: if ack_synced == req_toggle, go to IDLE and set ready_out <= 1. Otherwise go to WAIT_ACK.
- WAIT_ACK: at the first edge with ack_synced == req_toggle, go to IDLE and set ready_out <= 1.
- data_out and req_toggle change only on an accept. They never change in HOLD or WAIT_ACK.
- ack_toggle edges seen in IDLE or HOLD are only compared, never latched as events. A spurious or early ack therefore cannot skip the hold period.
- Width rules:
  - Counter width is $clog2(HOLD_CYCLES)+1.
  - Counter compare is unsigned.
  - Counter saturates at 0 and never wraps.
- If reset_n is asserted mid-transfer, all state returns to reset values immediately. The word in flight is abandoned. The destination side must be reset together with this block, or the toggles lose parity.

## Timing
- Accept at edge T: data_out and req_toggle are updated after T; ready_out is low from T.
- Without ACK: ready_out is high after edge T+HOLD_CYCLES. The earliest next accept is at T+HOLD_CYCLES+1. Throughput is one word per HOLD_CYCLES+1 cycles.
- With ACK: ready_out rises at edge max(T+HOLD_CYCLES, A+SYNC_TIMES), where A is the first edge at which ack_toggle is sampled at its new value.
- There is no combinational path from any input to any output. ready_out, busy, data_out and req_toggle are all flops or decoded from flops.

## Configuration
- CDC_SENDER_ACK_EN defined:
  - The ack path is compiled in: ack_toggle, the sync chain and the WAIT_ACK state.
  - Each new word waits for both the hold time and the matching ack.
- CDC_SENDER_ACK_EN undefined:
  - The ack path, the sync chain and WAIT_ACK are removed.
  - The ack_toggle port remains but is ignored.
  - Pacing is purely time-based via HOLD_CYCLES.
  - req_toggle still toggles on each launch.

## Structure
- Shared package cdc_pkg holds:
  - the state encoding constants CDC_ST_IDLE=2'd0, CDC_ST_HOLD=2'd1, CDC_ST_WAIT_ACK=2'd2;
  - the counter-width helper.
- One sub-module, cdc_ack_sync: a 1-bit, SYNC_TIMES-deep flop chain with asynchronous active-low reset to 0. It is instantiated only under CDC_SENDER_ACK_EN.

## Test plan
- Reset with reset_n=0 and then release → all outputs 0 during reset; ready_out=1 one edge after release.
- ACK off, HOLD_CYCLES=4, valid_in held with words 0x11 and 0x22 → data_out=0x11 for exactly 5 cycles, then 0x22; req_toggle goes 0→1→0.
- ACK on, HOLD_CYCLES=2, ack returned 10 cycles after req, SYNC_TIMES=3 → WAIT_ACK entered; ready_out rises 3 edges after ack_toggle flips; data_out stays 0x11 throughout.
- ACK on, ack returned instantly (ack_toggle tied to req_toggle) → WAIT_ACK never entered; pacing identical to the ACK-off case.
- ACK on, ack_toggle pulsed in IDLE and at the start of HOLD → no early ready_out; data_out stable for the full HOLD_CYCLES.
- reset_n asserted in the middle of HOLD with data_out=0xA5 → data_out=0 and req_toggle=0 immediately; the next accept works normally after release.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC launch path: FSM state encoding and the
// hold-counter width helper used by cdc_sender.
package cdc_pkg;

  // Launcher FSM states; encodings are fixed so they stay stable across
  // builds and match existing waveform decoders.
  typedef enum logic [1:0] {
    CDC_ST_IDLE     = 2'd0,
    CDC_ST_HOLD     = 2'd1,
    CDC_ST_WAIT_ACK = 2'd2
  } cdc_state_e;

  // Hold counter width: wide enough for HOLD_CYCLES-1 plus one spare bit.
  function automatic int unsigned cdc_cnt_width(input int unsigned hold_cycles);
    return $clog2(hold_cycles) + 1;
  endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// 1-bit multi-flop synchronizer for the ack toggle returning from the
// destination domain. Chain resets to 0 asynchronously.
module cdc_ack_sync #(
  parameter int unsigned SYNC_TIMES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ack_async,
  output logic ack_synced
);

  logic [SYNC_TIMES-1:0] chain;

  // Shift the asynchronous ack through SYNC_TIMES flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_TIMES-2:0], ack_async};
    end
  end

  assign ack_synced = chain[SYNC_TIMES-1];

endmodule

// File: rtl/cdc_sender.sv
// Source-domain launcher for the multi-flop CDC synchronizer. Accepts words
// on a valid/ready handshake, launches them onto data_out, flips req_toggle
// per word and holds data_out for at least HOLD_CYCLES source cycles.
// Optional feature macro: CDC_SENDER_ACK_EN -- when defined, each new word
// additionally waits for the synchronized ack_toggle to match req_toggle.
module cdc_sender
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned SYNC_TIMES  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  req_toggle,
  input  logic                  ack_toggle,
  output logic                  busy
);

  localparam int unsigned       CNT_W     = cdc_cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  cdc_state_e       state;
  cdc_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             ready_d;
  logic             ack_match;

`ifdef CDC_SENDER_ACK_EN
  logic ack_synced;

  cdc_ack_sync #(
    .SYNC_TIMES(SYNC_TIMES)
  ) u_ack_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .ack_async (ack_toggle),
    .ack_synced(ack_synced)
  );

  // Level compare only: an ack edge is never latched, so an early or
  // spurious ack cannot shorten the hold period.
  assign ack_match = (ack_synced == req_toggle);
`else
  localparam int unsigned SYNC_TIMES_UNUSED = SYNC_TIMES;
  logic ack_unused;

  assign ack_unused = ack_toggle;
  assign ack_match  = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CDC_ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      CDC_ST_IDLE: begin
        if (accept) begin
          state_next = CDC_ST_HOLD;
        end
      end
      CDC_ST_HOLD: begin
        if (cnt == '0) begin
`ifdef CDC_SENDER_ACK_EN
          state_next = ack_match ? CDC_ST_IDLE : CDC_ST_WAIT_ACK;
`else
          state_next = CDC_ST_IDLE;
`endif
        end
      end
      CDC_ST_WAIT_ACK: begin
        if (ack_match) begin
          state_next = CDC_ST_IDLE;
        end
      end
      default: state_next = CDC_ST_IDLE;
    endcase
  end

  // Output decode: accept strobe, next ready value and busy flag.
  always_comb begin
    accept  = (state == CDC_ST_IDLE) && valid_in && ready_out;
    // Ready is high exactly when the FSM is (next) idle and not accepting;
    // an accept always moves state_next to HOLD, so this covers both.
    ready_d = (state_next == CDC_ST_IDLE);
    busy    = (state != CDC_ST_IDLE);
  end

  // Registered ready; low out of reset, rises on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_out <= 1'b0;
    end else begin
      ready_out <= ready_d;
    end
  end

  // Launch register and request toggle; updated only on an accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      req_toggle <= 1'b0;
    end else if (accept) begin
      data_out   <= data_in;
      req_toggle <= ~req_toggle;
    end
  end

  // Hold counter: loaded on accept, counts down in HOLD, saturates at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= HOLD_LOAD;
    end else if ((state == CDC_ST_HOLD) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_sender.sv
// Self-checking bench for cdc_sender: directed steps plus randomized
// handshake traffic against a cycle-indexed reference model.
module tb_cdc_sender;

  localparam int unsigned DW = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned S  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          req_toggle;
  logic          ack_toggle;
  logic          busy;

  always #5 clk = ~clk;

  cdc_sender #(
    .DATA_WIDTH (DW),
    .HOLD_CYCLES(H),
    .SYNC_TIMES (S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .req_toggle(req_toggle),
    .ack_toggle(ack_toggle),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: e = edge index since reset release, m_t = edge of the
  // last accept. Ready after edge e requires e >= m_t + H (and, with ack,
  // the ack value sampled at edge e-S equal to the current request).
  int            e;
  int            m_t;
  logic          m_tog;
  logic [DW-1:0] m_data;
  logic          m_ready;

`ifdef CDC_SENDER_ACK_EN
  logic ack_hist [0:4095];
  logic ack_base;
  bit   ack_pending;
  int   ack_due;
  int   ack_delay;
  bit   rand_delay;
  bit   pulses_on;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e       = 0;
    m_t     = -int'(H);
    m_tog   = 1'b0;
    m_data  = '0;
    m_ready = 1'b0;
`ifdef CDC_SENDER_ACK_EN
    ack_base    = 1'b0;
    ack_pending = 1'b0;
`endif
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at +1.
  task automatic step(input logic v, input logic [DW-1:0] d, output bit acc);
    bit ok;
`ifdef CDC_SENDER_ACK_EN
    logic seen;
`endif
    acc      = 1'b0;
    ok       = 1'b1;
    valid_in = v;
    data_in  = d;
`ifdef CDC_SENDER_ACK_EN
    if (ack_pending && e >= ack_due) begin
      ack_base    = m_tog;
      ack_pending = 1'b0;
    end
    ack_toggle = ack_base ^ (pulses_on && ($urandom_range(0, 5) == 0));
    ack_hist[e] = ack_toggle;
    seen = (e >= int'(S)) ? ack_hist[e-int'(S)] : 1'b0;
    ok   = (seen == m_tog);
`else
    ack_toggle = 1'($urandom_range(0, 1));
`endif
    @(posedge clk);
    if (m_ready) begin
      if (v) begin
        acc     = 1'b1;
        m_data  = d;
        m_tog   = ~m_tog;
        m_t     = e;
        m_ready = 1'b0;
`ifdef CDC_SENDER_ACK_EN
        if (rand_delay) ack_delay = int'($urandom_range(0, 12));
        ack_pending = 1'b1;
        ack_due     = e + 1 + ack_delay;
`endif
      end
    end else if (e >= m_t + int'(H) && ok) begin
      m_ready = 1'b1;
    end
    e++;
    #1;
    check("data_out",   32'(data_out),   32'(m_data));
    check("req_toggle", 32'(req_toggle), 32'(m_tog));
    check("ready_out",  32'(ready_out),  32'(m_ready));
    check("busy",       32'(busy),       32'(!m_ready));
    @(negedge clk);
  endtask

  task automatic run_random(input int n);
    bit            acc;
    bit            src_v;
    logic [DW-1:0] src_d;
    src_v = 1'b0;
    src_d = '0;
    for (int i = 0; i < n; i++) begin
      if (!src_v && ($urandom_range(0, 3) != 0)) begin
        src_v = 1'b1;
        src_d = DW'($urandom_range(0, 255));
      end
      step(src_v, src_d, acc);
      if (acc) src_v = 1'b0;
    end
  endtask

  initial begin
    bit acc;
    int n11;

    reset_n    = 1'b0;
    valid_in   = 1'b0;
    data_in    = '0;
    ack_toggle = 1'b0;
`ifdef CDC_SENDER_ACK_EN
    ack_delay  = 0;
    rand_delay = 1'b0;
    pulses_on  = 1'b0;
`endif
    model_reset();

    // Reset state, with valid asserted to show it is ignored.
    repeat (2) @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'h5A;
    @(negedge clk);
    #1;
    check("rst_data_out",   32'(data_out),   32'h0);
    check("rst_req_toggle", 32'(req_toggle), 32'h0);
    check("rst_ready_out",  32'(ready_out),  32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    reset_n  = 1'b1;

    // Two back-to-back words with valid held: 0x11 visible for H+1 cycles.
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(1'b1, 8'h11, acc);
    check("accept_0x11", 32'(acc), 32'h1);
    n11 = (data_out == 8'h11) ? 1 : 0;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      step(1'b1, 8'h22, acc);
      if (data_out == 8'h11) n11++;
    end
    check("accept_0x22", 32'(acc), 32'h1);
    check("hold_len_0x11", 32'(n11), 32'(H + 1));
    check("toggle_after_two", 32'(req_toggle), 32'h0);

    run_random(200);

`ifdef CDC_SENDER_ACK_EN
    // Late ack: forces WAIT_ACK, ready tracks ack arrival plus sync delay.
    ack_delay = 10;
    run_random(150);
    // Random ack latency with spurious ack pulses.
    rand_delay = 1'b1;
    pulses_on  = 1'b1;
    run_random(400);
    rand_delay = 1'b0;
    pulses_on  = 1'b0;
    ack_delay  = 0;
    run_random(40);
`endif

    // Reset in the middle of HOLD with 0xA5 in flight.
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, 8'hA5, acc);
    check("accept_0xA5", 32'(acc), 32'h1);
    step(1'b0, 8'h00, acc);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_data_out",   32'(data_out),   32'h0);
    check("midrst_req_toggle", 32'(req_toggle), 32'h0);
    check("midrst_ready_out",  32'(ready_out),  32'h0);
    check("midrst_busy",       32'(busy),       32'h0);
    repeat (2) @(negedge clk);
    ack_toggle = 1'b0;
    model_reset();
    reset_n = 1'b1;

    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(1'b1, 8'h3C, acc);
    check("accept_after_reset", 32'(acc), 32'h1);
    run_random(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
